// File: rtl/rv32i_mc_control_if.sv
// ---------------------------------------------------------------------------
// rv32i_mc_control_if
//   Bus bundle between the multi-cycle control unit and its surroundings:
//   the instruction fetch handshake, the two regfile read-port values and the
//   data-memory handshake.
//
//   imem_req   : fetch request, held until imem_valid      (master -> slave)
//   imem_addr  : fetch address, equals the current pc       (master -> slave)
//   imem_rdata : returned instruction word                  (slave  -> master)
//   imem_valid : instruction-return strobe                  (slave  -> master)
//   rs1_data   : regfile read port 0 value                  (slave  -> master)
//   rs2_data   : regfile read port 1 value                  (slave  -> master)
//   mem_re     : data memory read request                   (master -> slave)
//   mem_we     : data memory write request                  (master -> slave)
//   mem_ready  : data memory access complete                (slave  -> master)
// ---------------------------------------------------------------------------
interface rv32i_mc_control_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        output imem_req, imem_addr, mem_re, mem_we,
        input  imem_rdata, imem_valid, rs1_data, rs2_data, mem_ready
    );

    modport slave (
        input  imem_req, imem_addr, mem_re, mem_we,
        output imem_rdata, imem_valid, rs1_data, rs2_data, mem_ready
    );
endinterface

// File: rtl/rv32i_mc_control.sv
// ---------------------------------------------------------------------------
// rv32i_mc_control
//   Multi-cycle RV32I control unit. Fetches one instruction at a time,
//   decodes it into a registered control word and walks the datapath through
//   EX0/EX1, an optional MEM phase and WB, then computes the next pc.
//
//   clk, rst   : clock and synchronous active-high reset
//   bus        : fetch / regfile-read / data-memory bundle (master side)
//   instType   : 0 load 1 imm 2 store 3 reg 4 lui 5 auipc 6 brnch 7 jalr 8 jal
//   fun3, fun7 : ir[14:12], ir[30]
//   rd/rs1/rs2 : register fields (rs1 forced to 0 for lui)
//   pc         : pc of the current instruction
//   imm        : sign-extended immediate of the current instruction
//   reg_we     : one-cycle regfile write enable in WB (rd != 0)
//   halted     : core stopped (illegal opcode or misaligned target)
//   instret    : retired-instruction counter
// ---------------------------------------------------------------------------
module rv32i_mc_control #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          HALT_ON_MISALIGN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    rv32i_mc_control_if.master        bus,
    output logic [3:0]                instType,
    output logic [2:0]                fun3,
    output logic                      fun7,
    output logic [4:0]                rd,
    output logic [4:0]                rs1,
    output logic [4:0]                rs2,
    output logic [31:0]               pc,
    output logic [31:0]               imm,
    output logic                      reg_we,
    output logic                      halted,
    output logic [31:0]               instret
);

    typedef enum logic [3:0] {
        IT_LOAD = 4'd0, IT_IMM = 4'd1, IT_STORE = 4'd2, IT_REG  = 4'd3,
        IT_LUI  = 4'd4, IT_AUIPC = 4'd5, IT_BRNCH = 4'd6, IT_JALR = 4'd7,
        IT_JAL  = 4'd8
    } itype_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EX0, S_EX1, S_MEM, S_WB, S_HALT
    } state_e;

    typedef struct packed {
        itype_e      itype;
        logic [2:0]  fun3;
        logic        fun7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_t;

    // addi x0,x0,0
    localparam ctl_t CTL_NOP = '{itype: IT_IMM, fun3: 3'd0, fun7: 1'b0,
                                 rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] ir_q;
    ctl_t        ctl_q, ctl_d;
    logic        ir_load, ctl_load, retire;

    // ------------------------------------------------------------------
    // Decode of the latched instruction word
    // ------------------------------------------------------------------
    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;
    assign i_imm = {{20{ir_q[31]}}, ir_q[31:20]};
    assign s_imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign b_imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign j_imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign u_imm = {ir_q[31:12], 12'b0};

    itype_e      dec_type;
    logic [31:0] dec_imm;
    logic        dec_legal;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statements can leave it holding a stale value
    // (which would infer a latch).
    always_comb begin
        dec_type  = IT_IMM;
        dec_imm   = 32'd0;
        dec_legal = 1'b1;
        case (ir_q[6:0])
            7'b0000011: begin dec_type = IT_LOAD;  dec_imm = i_imm; end
            7'b0010011: begin dec_type = IT_IMM;   dec_imm = i_imm; end
            7'b0100011: begin dec_type = IT_STORE; dec_imm = s_imm; end
            7'b0110011: begin dec_type = IT_REG;                    end
            7'b0110111: begin dec_type = IT_LUI;   dec_imm = u_imm; end
            7'b0010111: begin dec_type = IT_AUIPC; dec_imm = u_imm; end
            7'b1100011: begin
                dec_type = IT_BRNCH;
                dec_imm  = b_imm;
                // fun3 010/011 are unassigned branch encodings
                if (ir_q[14:13] == 2'b01) dec_legal = 1'b0;
            end
            7'b1100111: begin dec_type = IT_JALR;  dec_imm = i_imm; end
            7'b1101111: begin dec_type = IT_JAL;   dec_imm = j_imm; end
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        ctl_d.itype = dec_type;
        ctl_d.fun3  = ir_q[14:12];
        ctl_d.fun7  = ir_q[30];
        ctl_d.rd    = ir_q[11:7];
        // lui is executed as x0 + imm, so rs1 must read x0
        ctl_d.rs1   = (dec_type == IT_LUI) ? 5'd0 : ir_q[19:15];
        ctl_d.rs2   = ir_q[24:20];
        ctl_d.imm   = dec_imm;
    end

    // ------------------------------------------------------------------
    // Branch resolution and next-pc
    // ------------------------------------------------------------------
    logic        br_taken;
    logic [31:0] next_pc;
    logic        halt_mis;

    always_comb begin
        case (ctl_q.fun3)
            3'b000:  br_taken = (bus.rs1_data == bus.rs2_data);
            3'b001:  br_taken = (bus.rs1_data != bus.rs2_data);
            3'b100:  br_taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'b101:  br_taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'b110:  br_taken = (bus.rs1_data <  bus.rs2_data);
            3'b111:  br_taken = (bus.rs1_data >= bus.rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Only consumed in the retiring states, so it can depend on type alone.
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (ctl_q.itype)
            IT_BRNCH: if (br_taken) next_pc = pc_q + ctl_q.imm;
            IT_JAL:   next_pc = pc_q + ctl_q.imm;
            IT_JALR:  next_pc = (bus.rs1_data + ctl_q.imm) & ~32'd1;
            default:  ;
        endcase
    end

    assign halt_mis = HALT_ON_MISALIGN && (next_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        ir_load   = 1'b0;
        ctl_load  = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_valid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    ctl_load = 1'b1;
                    state_d  = S_EX0;
                end else begin
                    state_d  = S_HALT;
                end
            end
            S_EX0: state_d = S_EX1;
            S_EX1: begin
                case (ctl_q.itype)
                    IT_BRNCH:          retire  = 1'b1;
                    IT_LOAD, IT_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (ctl_q.itype == IT_LOAD) state_d = S_WB;
                    else                        retire  = 1'b1;
                end
            end
            S_WB:    retire = 1'b1;
            S_HALT:  ;
            default: state_d = S_HALT;
        endcase

        // Misaligned targets either stop the core without retiring or are
        // forced word-aligned; aligned targets pass through unchanged.
        if (retire) begin
            if (halt_mis) begin
                state_d = S_HALT;
            end else begin
                pc_d      = {next_pc[31:2], 2'b00};
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instret_q <= 32'd0;
            ctl_q     <= CTL_NOP;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            if (ctl_load) ctl_q <= ctl_d;
        end
    end

    // NOTE: ir is pure data, always written before it is decoded, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (ir_load) ir_q <= bus.imem_rdata;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // imem_req is masked by rst so the fetch port is quiet while held in reset.
    assign bus.imem_req  = (state_q == S_FETCH) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.mem_re    = (state_q == S_MEM) && (ctl_q.itype == IT_LOAD);
    assign bus.mem_we    = (state_q == S_MEM) && (ctl_q.itype == IT_STORE);

    assign instType = ctl_q.itype;
    assign fun3     = ctl_q.fun3;
    assign fun7     = ctl_q.fun7;
    assign rd       = ctl_q.rd;
    assign rs1      = ctl_q.rs1;
    assign rs2      = ctl_q.rs2;
    assign imm      = ctl_q.imm;
    assign pc       = pc_q;
    assign instret  = instret_q;
    assign halted   = (state_q == S_HALT);
    assign reg_we   = (state_q == S_WB) && (ctl_q.rd != 5'd0) && !halt_mis;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mc_control
//   Self-checking bench for rv32i_mc_control (RESET_PC=0x100, halting on
//   misaligned targets). Instructions are built from chosen fields by an
//   encoder; the expected decode, latency, next pc, write-enable and retire
//   behaviour are derived from those fields. Memories answer with random
//   wait states.
// ---------------------------------------------------------------------------
module tb_rv32i_mc_control;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam logic [6:0] OP_LD  = 7'b0000011, OP_IMM = 7'b0010011,
                           OP_ST  = 7'b0100011, OP_REG = 7'b0110011,
                           OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
                           OP_BR  = 7'b1100011, OP_JLR = 7'b1100111,
                           OP_JAL = 7'b1101111;

    localparam int K_ILLEGAL = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  instType;
    logic [2:0]  fun3;
    logic        fun7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, imm, instret;
    logic        reg_we, halted;

    rv32i_mc_control_if bus ();

    rv32i_mc_control #(.RESET_PC(RST_PC), .HALT_ON_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .instType(instType), .fun3(fun3), .fun7(fun7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .reg_we(reg_we), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [31:0] iv, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdd,
                                          input logic [6:0] op);
        return {iv[11:0], r1, f3, rdd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] iv, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {iv[11:5], r2, r1, f3, iv[4:0], OP_ST};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] iv, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], OP_BR};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] iv, input logic [4:0] rdd);
        return {iv[20], iv[10:1], iv[11], iv[19:12], rdd, OP_JAL};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] iv, input logic [4:0] rdd,
                                          input logic [6:0] op);
        return {iv[31:12], rdd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rdd);
        return {1'b0, f7, 5'b0, r2, r1, f3, rdd, OP_REG};
    endfunction

    // ---------------- reset sequence ----------------
    // Called at a negedge; returns #1 after the negedge of the first
    // post-release cycle, which is a FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        bus.imem_valid = 1'b1;       // must be ignored while in reset
        bus.imem_rdata = 32'h0000_0000;
        bus.mem_ready  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_imem_req", 32'(bus.imem_req), 32'd0);
            check("rst_mem_req", 32'(bus.mem_re | bus.mem_we), 32'd0);
            check("rst_reg_we", 32'(reg_we), 32'd0);
        end
        rst = 1'b0;
        bus.imem_valid = 1'b0;
        #1;
        check("rel_imem_req", 32'(bus.imem_req), 32'd1);
        check("rel_imem_addr", bus.imem_addr, RST_PC);
        check("rel_instType", 32'(instType), 32'd1);
        check("rel_rd", 32'(rd), 32'd0);
        check("rel_rs1", 32'(rs1), 32'd0);
        check("rel_imm", imm, 32'd0);
        check("rel_halted", 32'(halted), 32'd0);
        check("rel_instret", instret, 32'd0);
        m_pc   = RST_PC;
        m_inst = 32'd0;
    endtask

    // ---------------- one instruction against the model ----------------
    // Entered during a FETCH cycle (after its negedge). kind = expected
    // instType, or K_ILLEGAL for an unmapped opcode.
    task automatic run_instr(input int kind, input logic [31:0] ins, input logic [31:0] imm_v,
                             input logic [31:0] a, input logic [31:0] b,
                             input int iw, input int dw);
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [2:0]  e_f3;
        logic        e_f7, legal, taken, mis, halt_exp, writes;
        logic [31:0] tgt;
        int          exp_k, k, n_we, we_k, n_re, n_wr;

        e_rd  = ins[11:7];
        e_rs1 = (kind == 4) ? 5'd0 : ins[19:15];
        e_rs2 = ins[24:20];
        e_f3  = ins[14:12];
        e_f7  = ins[30];
        legal = (kind <= 8) && !(kind == 6 && (e_f3 == 3'd2 || e_f3 == 3'd3));

        case (e_f3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) <  $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a <  b);
            3'd7:    taken = (a >= b);
            default: taken = 1'b0;
        endcase

        case (kind)
            6:       tgt = taken ? m_pc + imm_v : m_pc + 32'd4;
            7:       tgt = (a + imm_v) & ~32'd1;
            8:       tgt = m_pc + imm_v;
            default: tgt = m_pc + 32'd4;
        endcase
        mis      = legal && (tgt[1:0] != 2'b00);
        halt_exp = !legal || mis;
        writes   = legal && !mis && (e_rd != 5'd0) &&
                   (kind inside {0, 1, 3, 4, 5, 7, 8});
        if (!legal)                      exp_k = 2;
        else if (kind == 6)              exp_k = 4;
        else if (kind == 0)              exp_k = 6 + dw;
        else if (kind == 2)              exp_k = 5 + dw;
        else                             exp_k = 5;

        bus.rs1_data = a;
        bus.rs2_data = b;
        check("fetch_req", 32'(bus.imem_req), 32'd1);
        check("fetch_addr", bus.imem_addr, m_pc);
        for (int i = 0; i < iw; i++) begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            check("fetch_wait_req", 32'(bus.imem_req), 32'd1);
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = ins;
        @(negedge clk);

        k = 1; n_we = 0; we_k = -1; n_re = 0; n_wr = 0;
        while (k <= 40) begin
            if (k >= 2 && (bus.imem_req || halted)) break;
            // stray strobes outside FETCH must have no effect
            bus.imem_valid = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            if (k == 2 && legal) begin
                check("instType", 32'(instType), 32'(kind));
                check("fun3", 32'(fun3), 32'(e_f3));
                check("fun7", 32'(fun7), 32'(e_f7));
                check("rd", 32'(rd), 32'(e_rd));
                check("rs1", 32'(rs1), 32'(e_rs1));
                check("rs2", 32'(rs2), 32'(e_rs2));
                check("cur_pc", pc, m_pc);
                if (kind != 3) check("imm", imm, imm_v);
            end
            if (bus.mem_re) n_re++;
            if (bus.mem_we) n_wr++;
            bus.mem_ready = (bus.mem_re || bus.mem_we) && ((n_re + n_wr) == dw + 1);
            if (reg_we) begin
                n_we++;
                we_k = k;
            end
            @(negedge clk);
            k++;
        end
        bus.imem_valid = 1'b0;
        bus.mem_ready  = 1'b0;

        check("latency", 32'(k), 32'(exp_k));
        check("halted", 32'(halted), 32'(halt_exp));
        check("reg_we_count", 32'(n_we), 32'(writes));
        if (writes) check("reg_we_cycle", 32'(we_k), 32'(exp_k - 1));
        check("mem_re_cycles", 32'(n_re), (legal && kind == 0) ? 32'(dw + 1) : 32'd0);
        check("mem_we_cycles", 32'(n_wr), (legal && kind == 2) ? 32'(dw + 1) : 32'd0);
        check("next_pc", pc, halt_exp ? m_pc : tgt);
        check("instret", instret, halt_exp ? m_inst : m_inst + 32'd1);

        if (halt_exp) begin
            for (int i = 0; i < 22; i++) begin
                bus.imem_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("halt_imem_req", 32'(bus.imem_req), 32'd0);
            end
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_pc_frozen", pc, m_pc);
            check("halt_instret_frozen", instret, m_inst);
            do_reset();
        end else begin
            m_pc   = tgt;
            m_inst = m_inst + 32'd1;
        end
    endtask

    // ---------------- random instruction generator ----------------
    task automatic run_random();
        int          sel, kind, v;
        logic [4:0]  rdd, r1, r2;
        logic [2:0]  f3;
        logic [31:0] ins, iv, a, b;
        logic [6:0]  bad_ops [4];
        bit          odd;

        bad_ops = '{7'h00, 7'h7F, 7'h0F, 7'h73};
        sel  = int'($urandom_range(0, 19));
        rdd  = 5'($urandom_range(0, 31));
        r1   = 5'($urandom_range(0, 31));
        r2   = 5'($urandom_range(0, 31));
        f3   = 3'($urandom_range(0, 7));
        a    = $urandom;
        b    = ($urandom_range(0, 2) == 0) ? a : $urandom;
        odd  = ($urandom_range(0, 7) == 0);
        v    = int'($urandom_range(0, 4095)) - 2048;
        iv   = v;
        kind = (sel < 18) ? sel % 9 : K_ILLEGAL;

        case (kind)
            0: ins = enc_i(iv, r1, f3, rdd, OP_LD);
            1: ins = enc_i(iv, r1, f3, rdd, OP_IMM);
            2: ins = enc_s(iv, r2, r1, f3);
            3: begin ins = enc_r(1'($urandom_range(0, 1)), r2, r1, f3, rdd); iv = 32'd0; end
            4: begin iv = {20'($urandom), 12'd0}; ins = enc_u(iv, rdd, OP_LUI); end
            5: begin iv = {20'($urandom), 12'd0}; ins = enc_u(iv, rdd, OP_AUI); end
            6: begin
                v  = (int'($urandom_range(0, 2047)) - 1024) * 4 + (odd ? 2 : 0);
                iv = v;
                if (sel == 6 || sel == 15) begin
                    // legal condition codes only
                    case ($urandom_range(0, 5))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4;
                        3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
                    endcase
                end
                ins = enc_b(iv, r2, r1, f3);
            end
            7: begin
                // choose a base so the target is aligned, off by 1 (bit 0
                // cleared), or occasionally off by 2
                a   = ($urandom & ~32'd3) - iv + 32'($urandom_range(0, 1)) + (odd ? 32'd2 : 32'd0);
                ins = enc_i(iv, r1, 3'd0, rdd, OP_JLR);
            end
            8: begin
                v   = (int'($urandom_range(0, 524287)) - 262144) * 4 + (odd ? 2 : 0);
                iv  = v;
                ins = enc_j(iv, rdd);
            end
            default: begin
                ins = $urandom;
                if (sel == 19) begin
                    ins[6:0]   = OP_BR;       // unassigned branch fun3
                    ins[14:12] = {2'b01, 1'($urandom_range(0, 1))};
                    kind = 6;
                end else begin
                    ins[6:0] = bad_ops[$urandom_range(0, 3)];
                end
            end
        endcase
        run_instr(kind, ins, iv, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        rst            = 1'b1;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.mem_ready  = 1'b0;
        bus.rs1_data   = 32'd0;
        bus.rs2_data   = 32'd0;
        @(negedge clk);
        do_reset();

        // addi x5,x0,7 at 0x100
        run_instr(1, enc_i(32'd7, 5'd0, 3'd0, 5'd5, OP_IMM), 32'd7, 32'd0, 32'd0, 0, 0);
        // beq x0,x0,8 taken, then bne x0,x0,8 not taken
        run_instr(6, enc_b(32'd8, 5'd0, 5'd0, 3'd0), 32'd8, 32'd3, 32'd3, 0, 0);
        run_instr(6, enc_b(32'd8, 5'd0, 5'd0, 3'd1), 32'd8, 32'd3, 32'd3, 0, 0);
        // lw x6,16(x2) with ready on the 4th MEM cycle
        run_instr(0, enc_i(32'd16, 5'd2, 3'd2, 5'd6, OP_LD), 32'd16, 32'h40, 32'd0, 1, 3);

        // second lw, reset while its MEM request is pending
        bus.imem_valid = 1'b1;
        bus.imem_rdata = enc_i(32'd4, 5'd2, 3'd2, 5'd7, OP_LD);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        guard = 0;
        while (!bus.mem_re && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("mid_mem_re_seen", 32'(bus.mem_re), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_mem_re", 32'(bus.mem_re), 32'd0);
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_instret", instret, 32'd0);
        do_reset();

        // jalr x1,5(x2) with x2=0x200 -> 0x204
        run_instr(7, enc_i(32'd5, 5'd2, 3'd0, 5'd1, OP_JLR), 32'd5, 32'h200, 32'd0, 0, 0);
        // jal x3,6 -> misaligned target halts
        run_instr(8, enc_j(32'd6, 5'd3), 32'd6, 32'd0, 32'd0, 0, 0);
        // all-zero word is illegal
        run_instr(K_ILLEGAL, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 0, 0);

        repeat (300) run_random();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
